cnt_sync_tracker: RTL and testbench

- Downstream consumer of a free-running 4-bit binary count produced in a foreign clock domain, such as either output of the dual-clock counter.
- Resynchronises the asynchronous count into the local clk domain and accepts only stable values.
- Accumulates legal increments into a wide extended count, flags wrap-around, upstream jumps/resets and stalls.
- Sits between the dual-clock counter and local monitoring/STA logic.

---
 rtl/cnt_sync_tracker.sv | 169 ++++++++++++++++
 tb/tb_cnt_sync_tracker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_sync_tracker.sv
// Resynchronises a foreign-domain binary count, accepts stable values and tracks them as a wide extended count.
// Optional `CNT_SYNC_TRACKER_ERRCNT_EN adds a saturating jump counter output err_count.
module cnt_sync_tracker #(
  parameter int CNT_W        = 4,
  parameter int EXT_W        = 16,
  parameter int STABLE_N     = 2,
  parameter int MAX_STEP     = 4,
  parameter int STALL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             valid,
  output logic [CNT_W-1:0] cnt_sync,
  output logic             upd_pulse,
  output logic [CNT_W-1:0] delta,
  output logic             wrap_pulse,
  output logic             jump_pulse,
  output logic [EXT_W-1:0] ext_count,
  output logic             stall
`ifdef CNT_SYNC_TRACKER_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int SW = $clog2(STABLE_N + 1);
  localparam int TW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0]    STAB_MAX  = SW'(STABLE_N);
  localparam logic [TW-1:0]    TIMER_MAX = TW'(STALL_CYCLES);
  localparam logic [CNT_W-1:0] STEP_MAX  = CNT_W'(MAX_STEP);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_STALL} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] sync1, sync2, prev;
  logic             s1_ok, s2_ok, prev_ok;
  logic [SW-1:0]    stab_cnt, stab_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic             same, qualify, accept, legal;
  logic [CNT_W-1:0] d_raw;

  logic [CNT_W-1:0] cnt_nxt, delta_nxt;
  logic [EXT_W-1:0] ext_nxt;
  logic             upd_nxt, wrap_nxt, jump_nxt;

  // The *_ok flags keep the zeros left in the chain by reset from ever being counted as a sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      s1_ok    <= 1'b0;
      s2_ok    <= 1'b0;
      prev_ok  <= 1'b0;
      stab_cnt <= '0;
      timer    <= '0;
    end else begin
      sync1    <= cnt_in;
      sync2    <= sync1;
      prev     <= sync2;
      s1_ok    <= 1'b1;
      s2_ok    <= s1_ok;
      prev_ok  <= s2_ok;
      stab_cnt <= stab_nxt;
      timer    <= timer_nxt;
    end
  end

  // stab_cnt counts consecutive equal samples of sync2, saturating once the value has qualified.
  always_comb begin
    same     = prev_ok && (sync2 == prev);
    stab_nxt = '0;
    if (s2_ok) begin
      if (!same)
        stab_nxt = SW'(1);
      else if (stab_cnt == STAB_MAX)
        stab_nxt = STAB_MAX;
      else
        stab_nxt = stab_cnt + SW'(1);
    end
    qualify = s2_ok && (stab_nxt == STAB_MAX) && !(same && (stab_cnt == STAB_MAX));
    accept  = qualify && ((state == S_IDLE) || (sync2 != cnt_sync));
    d_raw   = sync2 - cnt_sync;
    legal   = (d_raw <= STEP_MAX);
  end

  always_comb begin
    timer_nxt = timer;
    if (accept || (state == S_IDLE))
      timer_nxt = '0;
    else if (timer != TIMER_MAX)
      timer_nxt = timer + TW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_TRACK;
      S_TRACK: if (!accept && (timer_nxt == TIMER_MAX)) state_nxt = S_STALL;
      S_STALL: if (accept) state_nxt = S_TRACK;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A STALL-state acceptance is handled exactly like a TRACK one; only the IDLE load is special.
  always_comb begin
    cnt_nxt   = cnt_sync;
    delta_nxt = delta;
    ext_nxt   = ext_count;
    upd_nxt   = 1'b0;
    wrap_nxt  = 1'b0;
    jump_nxt  = 1'b0;
    if (accept) begin
      cnt_nxt = sync2;
      upd_nxt = 1'b1;
      if (state == S_IDLE) begin
        delta_nxt = '0;
      end else begin
        delta_nxt = d_raw;
        if (legal) begin
          ext_nxt  = ext_count + EXT_W'(d_raw);
          wrap_nxt = (sync2 < cnt_sync);
        end else begin
          jump_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_sync   <= '0;
      delta      <= '0;
      ext_count  <= '0;
      upd_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      jump_pulse <= 1'b0;
    end else begin
      cnt_sync   <= cnt_nxt;
      delta      <= delta_nxt;
      ext_count  <= ext_nxt;
      upd_pulse  <= upd_nxt;
      wrap_pulse <= wrap_nxt;
      jump_pulse <= jump_nxt;
    end
  end

  assign valid = (state != S_IDLE);
  assign stall = (state == S_STALL);

`ifdef CNT_SYNC_TRACKER_ERRCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_count <= '0;
    else if (jump_nxt && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cnt_sync_tracker.sv
// Self-checking bench for cnt_sync_tracker: directed test-plan steps plus randomized counting against a sample-history model.
// Also checks err_count when CNT_SYNC_TRACKER_ERRCNT_EN is defined.
module tb_cnt_sync_tracker;

  localparam int CNT_W        = 4;
  localparam int EXT_W        = 16;
  localparam int STABLE_N     = 2;
  localparam int MAX_STEP     = 4;
  localparam int STALL_CYCLES = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] cnt_in = '0;
  logic             valid, upd_pulse, wrap_pulse, jump_pulse, stall;
  logic [CNT_W-1:0] cnt_sync, delta;
  logic [EXT_W-1:0] ext_count;
`ifdef CNT_SYNC_TRACKER_ERRCNT_EN
  logic [7:0]       err_count;
`endif

  cnt_sync_tracker #(
    .CNT_W(CNT_W), .EXT_W(EXT_W), .STABLE_N(STABLE_N),
    .MAX_STEP(MAX_STEP), .STALL_CYCLES(STALL_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in),
    .valid(valid), .cnt_sync(cnt_sync), .upd_pulse(upd_pulse), .delta(delta),
    .wrap_pulse(wrap_pulse), .jump_pulse(jump_pulse), .ext_count(ext_count), .stall(stall)
`ifdef CNT_SYNC_TRACKER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: every value sampled at a clk edge since reset, plus the tracker's visible state.
  int hist[$];
  bit m_valid, m_upd, m_wrap, m_jump, m_stall;
  int m_cnt, m_delta, m_ext, m_err, m_since;
  int upd_seen, wrap_seen, jump_seen;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_valid = 0; m_upd = 0; m_wrap = 0; m_jump = 0; m_stall = 0;
    m_cnt = 0; m_delta = 0; m_ext = 0; m_err = 0; m_since = 0;
  endtask

  // A value is accepted two edges after it has been sampled STABLE_N times in a row, once per run.
  task automatic model_step();
    int k, c, d;
    bit qual;
    m_upd = 0; m_wrap = 0; m_jump = 0;
    hist.push_back(int'(cnt_in));
    k = hist.size();
    qual = 0;
    c = 0;
    if (k - 2 - STABLE_N >= 0) begin
      c = hist[k-3];
      qual = 1;
      for (int i = k - 2 - STABLE_N; i <= k - 3; i++)
        if (hist[i] != c) qual = 0;
      if ((k - 3 - STABLE_N >= 0) && (hist[k-3-STABLE_N] == c)) qual = 0;
    end
    if (qual && (!m_valid || c != m_cnt)) begin
      m_upd = 1;
      if (!m_valid) begin
        m_valid = 1;
        m_delta = 0;
      end else begin
        d = (c - m_cnt) & ((1 << CNT_W) - 1);
        m_delta = d;
        if (d <= MAX_STEP) begin
          m_ext  = (m_ext + d) % (1 << EXT_W);
          m_wrap = (c < m_cnt);
        end else begin
          m_jump = 1;
          if (m_err < 255) m_err++;
        end
      end
      m_cnt   = c;
      m_since = 0;
      m_stall = 0;
    end else if (m_valid) begin
      if (m_since < STALL_CYCLES) m_since++;
      m_stall = (m_since >= STALL_CYCLES);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  always @(posedge clk) begin
    #2;
    if (upd_pulse)  upd_seen++;
    if (wrap_pulse) wrap_seen++;
    if (jump_pulse) jump_seen++;
  end

  always @(negedge clk) begin
    checkOutput("valid", valid, m_valid);
    checkOutput("cnt_sync", cnt_sync, m_cnt);
    checkOutput("upd_pulse", upd_pulse, m_upd);
    checkOutput("delta", delta, m_delta);
    checkOutput("wrap_pulse", wrap_pulse, m_wrap);
    checkOutput("jump_pulse", jump_pulse, m_jump);
    checkOutput("ext_count", ext_count, m_ext);
    checkOutput("stall", stall, m_stall);
`ifdef CNT_SYNC_TRACKER_ERRCNT_EN
    checkOutput("err_count", err_count, m_err);
`endif
  end

  task automatic applyStimulus(input int value, input int cycles);
    cnt_in = CNT_W'(value);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_upd(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!upd_pulse && n < 12);
    checkOutput(name, upd_pulse, 1);
  endtask

  initial begin
    int cur, nxt, hold, r;
    upd_seen = 0; wrap_seen = 0; jump_seen = 0;
    model_reset();

    // First value after reset release lands on the 4th edge.
    cnt_in = 4'h3;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("valid_before_edge4", valid, 0);
    @(negedge clk);
    checkOutput("first_valid", valid, 1);
    checkOutput("first_cnt", cnt_sync, 3);
    checkOutput("first_upd", upd_pulse, 1);
    checkOutput("first_delta", delta, 0);
    checkOutput("first_ext", ext_count, 0);

    upd_seen = 0;
    applyStimulus(4, 10);
    applyStimulus(5, 10);
    applyStimulus(6, 10);
    checkOutput("step_upd_count", upd_seen, 3);
    checkOutput("step_delta", delta, 1);
    checkOutput("step_ext", ext_count, 3);

    applyStimulus(10, 10);
    applyStimulus(14, 10);
    wrap_seen = 0;
    applyStimulus(15, 10);
    applyStimulus(0, 10);
    applyStimulus(1, 10);
    checkOutput("ramp_wrap_count", wrap_seen, 1);
    checkOutput("ramp_ext", ext_count, 14);

    applyStimulus(5, 10);
    applyStimulus(9, 10);
    checkOutput("pre_jump_ext", ext_count, 22);
    jump_seen = 0;
    applyStimulus(0, 10);
    checkOutput("jump_count", jump_seen, 1);
    checkOutput("jump_delta", delta, 7);
    checkOutput("jump_cnt", cnt_sync, 0);
    checkOutput("jump_ext", ext_count, 22);
`ifdef CNT_SYNC_TRACKER_ERRCNT_EN
    checkOutput("jump_err_count", err_count, 1);
`endif

    applyStimulus(4, 10);
    applyStimulus(5, 10);
    upd_seen = 0;
    applyStimulus(7, 1);
    applyStimulus(5, 10);
    checkOutput("glitch_upd_count", upd_seen, 0);
    checkOutput("glitch_cnt", cnt_sync, 5);

    cnt_in = 4'h6;
    wait_upd("stall_setup_upd");
    repeat (31) @(negedge clk);
    checkOutput("stall_edge31", stall, 0);
    @(negedge clk);
    checkOutput("stall_edge32", stall, 1);
    repeat (8) @(negedge clk);
    cnt_in = 4'h7;
    wait_upd("stall_exit_upd");
    checkOutput("stall_exit_stall", stall, 0);
    checkOutput("stall_exit_delta", delta, 1);

    repeat (40) @(negedge clk);
    checkOutput("stall_again", stall, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", valid, 0);
    checkOutput("async_rst_cnt", cnt_sync, 0);
    checkOutput("async_rst_ext", ext_count, 0);
    checkOutput("async_rst_delta", delta, 0);
    checkOutput("async_rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Mostly legal counting with occasional jumps, one-cycle glitches, long holds and resets.
    cur = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      r = $urandom_range(0, 19);
      hold = (r == 19) ? 40 : $urandom_range(1, 10);
      if (r < 13) begin
        nxt = (cur + $urandom_range(0, MAX_STEP)) & 15;
        applyStimulus(nxt, hold);
        cur = nxt;
      end else if (r < 16) begin
        nxt = $urandom_range(0, 15);
        applyStimulus(nxt, hold);
        cur = nxt;
      end else if (r < 18) begin
        applyStimulus($urandom_range(0, 15), 1);
        applyStimulus(cur, hold);
      end else if (r == 18) begin
        #($urandom_range(1, 3)) rst = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #2 rst = 1'b1;
      end else begin
        applyStimulus(cur, hold);
      end
    end

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
